// File: rtl/seq_tracker.sv
// -----------------------------------------------------------------------------
// seq_tracker
//  Receive-side companion to the PWM pattern generator. It watches the 4-bit
//  pattern stream, one sample per generator step. From that stream it recovers
//  the generator's 16-state position and its count direction. It then locks
//  onto the stream, and it flags and counts pattern errors.
//
// Parameters
//  ERR_W    width of the saturating error counter
//  CONFIRM  number of consecutive correct predictions in VERIFY before locked
//           asserts (0 = lock as soon as the position is resolved)
//
// Ports
//  clk      in   rising-edge clock
//  rst      in   asynchronous, active-high reset
//  smp_vld  in   seq_in is valid this cycle
//  seq_in   in   observed 4-bit pattern value
//  idx      out  recovered state index (0 unless VERIFY/LOCKED)
//  dir_up   out  1 = counting up, 0 = down (0 unless VERIFY/LOCKED)
//  locked   out  high only in LOCKED
//  err      out  one-cycle pulse per erroneous sample
//  err_cnt  out  saturating error count
// -----------------------------------------------------------------------------
module seq_tracker #(
   parameter int ERR_W   = 8,
   parameter int CONFIRM = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             smp_vld,
   input  logic [3:0]       seq_in,
   output logic [3:0]       idx,
   output logic             dir_up,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int CW = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      VERIFY  = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   // Generator pattern table
   function automatic logic [3:0] pat_of(input logic [3:0] i);
      logic [3:0] r;
      case (i)
         4'h0: r = 4'h0;  4'h1: r = 4'h7;  4'h2: r = 4'hc;  4'h3: r = 4'hb;
         4'h4: r = 4'hf;  4'h5: r = 4'h2;  4'h6: r = 4'h5;  4'h7: r = 4'h3;
         4'h8: r = 4'hd;  4'h9: r = 4'h8;  4'ha: r = 4'hb;  4'hb: r = 4'h8;
         4'hc: r = 4'ha;  4'hd: r = 4'h7;  4'he: r = 4'h4;  4'hf: r = 4'hd;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   // Set of indices that emit value v; empty for values the generator never emits
   function automatic logic [15:0] mask_of(input logic [3:0] v);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         if (pat_of(4'(i)) == v) begin
            r[i] = 1'b1;
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [4:0] popcnt(input logic [15:0] x);
      logic [4:0] r;
      r = 5'd0;
      for (int i = 0; i < 16; i++) begin
         r = r + {4'd0, x[i]};
      end
      return r;
   endfunction

   // Index of the (single) set bit
   function automatic logic [3:0] bit_idx(input logic [15:0] x);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (x[i]) begin
            r = 4'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [15:0]      cu_q, cu_d, cd_q, cd_d;
   logic [CW-1:0]    conf_q, conf_d;
   logic [3:0]       idx_q, idx_d;
   logic             dir_up_q, dir_up_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [15:0]      m_s, cu_adv_s, cd_adv_s;
   logic [5:0]       n_s;
   logic [3:0]       pred_s;
   logic [CW-1:0]    conf_inc_s;
   logic             reseed_s;

   // Next-state and output computation for one sample
   always_comb begin
      m_s        = mask_of(seq_in);
      // Up hypothesis advances index+1, down hypothesis index-1
      cu_adv_s   = {cu_q[14:0], cu_q[15]} & m_s;
      cd_adv_s   = {cd_q[0], cd_q[15:1]} & m_s;
      // An index surviving in both masks counts twice: direction unresolved
      n_s        = {1'b0, popcnt(cu_adv_s)} + {1'b0, popcnt(cd_adv_s)};
      pred_s     = dir_up_q ? (idx_q + 4'd1) : (idx_q - 4'd1);
      conf_inc_s = conf_q + CW'(1);
      reseed_s   = 1'b0;
      state_d    = state_q;
      cu_d       = cu_q;
      cd_d       = cd_q;
      conf_d     = conf_q;
      idx_d      = idx_q;
      dir_up_d   = dir_up_q;
      locked_d   = locked_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      if (smp_vld) begin
         case (state_q)
            SEARCH: begin
               reseed_s = 1'b1;
               err_d    = (m_s == 16'h0000);
            end
            ACQUIRE: begin
               cu_d = cu_adv_s;
               cd_d = cd_adv_s;
               if (n_s == 6'd0) begin
                  err_d    = 1'b1;
                  reseed_s = 1'b1;
               end else if (n_s == 6'd1) begin
                  idx_d    = bit_idx(cu_adv_s | cd_adv_s);
                  dir_up_d = |cu_adv_s;
                  conf_d   = CW'(0);
                  state_d  = (CONFIRM == 0) ? LOCKED : VERIFY;
                  locked_d = (CONFIRM == 0);
               end else begin
                  state_d = ACQUIRE;
               end
            end
            VERIFY, LOCKED: begin
               if (seq_in == pat_of(pred_s)) begin
                  idx_d = pred_s;
                  if (state_q == VERIFY) begin
                     conf_d = conf_inc_s;
                     if (conf_inc_s == CW'(CONFIRM)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                     end else begin
                        state_d = VERIFY;
                     end
                  end else begin
                     state_d = LOCKED;
                  end
               end else begin
                  // Includes direction reversals; they are relearned via ACQUIRE
                  err_d    = 1'b1;
                  reseed_s = 1'b1;
               end
            end
            default: begin
               reseed_s = 1'b1;
            end
         endcase
         if (reseed_s) begin
            cu_d     = m_s;
            cd_d     = m_s;
            conf_d   = CW'(0);
            idx_d    = 4'd0;
            dir_up_d = 1'b0;
            locked_d = 1'b0;
            state_d  = (m_s == 16'h0000) ? SEARCH : ACQUIRE;
         end else begin
            reseed_s = 1'b0;
         end
         if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end else begin
         err_d = 1'b0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SEARCH;
         cu_q      <= 16'h0000;
         cd_q      <= 16'h0000;
         conf_q    <= CW'(0);
         idx_q     <= 4'd0;
         dir_up_q  <= 1'b0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= {ERR_W{1'b0}};
      end else begin
         state_q   <= state_d;
         cu_q      <= cu_d;
         cd_q      <= cd_d;
         conf_q    <= conf_d;
         idx_q     <= idx_d;
         dir_up_q  <= dir_up_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign idx     = idx_q;
   assign dir_up  = dir_up_q;
   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule
